// File: rtl/ime_search_ctrl_pkg.sv
// Shared definitions for the IME search controller: default widths, FSM encoding,
// partition indices and the se(v) Exp-Golomb length helper. MV layout is {mvy, mvx}.
package ime_search_ctrl_pkg;

  localparam int SR_DEF       = 16;
  localparam int MV_W_DEF     = 10;
  localparam int LAMBDA_W_DEF = 7;
  localparam int COST_W_DEF   = 16;
  localparam int MV_COST_BITS = 12;

  localparam int NPART    = 5;
  localparam int P16X16   = 0;
  localparam int P16X8_T  = 1;
  localparam int P16X8_B  = 2;
  localparam int P8X16_L  = 3;
  localparam int P8X16_R  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // se(v) length of a value with magnitude mag: 2*floor(log2(2*mag+1)) + 1.
  function automatic logic [6:0] se_len(input logic [31:0] mag);
    logic [32:0] v;
    v      = {mag, 1'b1};
    se_len = 7'd1;
    for (int i = 1; i < 33; i++) begin
      if (v[i]) se_len = 7'(2 * i + 1);
    end
  endfunction

endpackage

// File: rtl/ime_search_ctrl_mvd.sv
// ime_mvd_cost: combinational MV cost lambda * (len(mvx-mvp_x) + len(mvy-mvp_y)),
// saturated to MVC_W bits.
module ime_mvd_cost
  import ime_search_ctrl_pkg::*;
#(
  parameter int MV_W     = MV_W_DEF,
  parameter int LAMBDA_W = LAMBDA_W_DEF,
  parameter int MVC_W    = MV_COST_BITS
) (
  input  logic signed [MV_W-1:0]     mvx,
  input  logic signed [MV_W-1:0]     mvy,
  input  logic signed [MV_W-1:0]     mvp_x,
  input  logic signed [MV_W-1:0]     mvp_y,
  input  logic        [LAMBDA_W-1:0] lambda,
  output logic        [MVC_W-1:0]    cost
);

  localparam int DW = MV_W + 1;
  localparam int PW = LAMBDA_W + 8;

  logic [DW-1:0] dx, dy, ax, ay;
  logic [7:0]    len_sum;
  logic [PW-1:0] prod;

  always_comb begin
    // NOTE: every variable is assigned on every path, so no latch can be inferred.
    dx      = {mvx[MV_W-1], mvx} - {mvp_x[MV_W-1], mvp_x};
    dy      = {mvy[MV_W-1], mvy} - {mvp_y[MV_W-1], mvp_y};
    ax      = dx[DW-1] ? (~dx + DW'(1)) : dx;
    ay      = dy[DW-1] ? (~dy + DW'(1)) : dy;
    len_sum = 8'(se_len(32'(ax))) + 8'(se_len(32'(ay)));
    prod    = PW'(lambda) * PW'(len_sum);
    cost    = (prod > PW'({MVC_W{1'b1}})) ? {MVC_W{1'b1}} : prod[MVC_W-1:0];
  end

endmodule

// File: rtl/ime_search_ctrl.sv
// Full-search IME controller: raster candidate issue, MV cost, per-partition best tracking.
// Optional early termination on a low 16x16 cost is enabled by defining IME_EARLY_TERM_EN.
module ime_search_ctrl
  import ime_search_ctrl_pkg::*;
#(
  parameter int SR       = SR_DEF,
  parameter int MV_W     = MV_W_DEF,
  parameter int LAMBDA_W = LAMBDA_W_DEF,
  parameter int COST_W   = COST_W_DEF,
  parameter int MVC_W    = MV_COST_BITS
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start_i,
  input  logic        [LAMBDA_W-1:0] lambda_i,
  input  logic signed [MV_W-1:0]     mvp_x_i,
  input  logic signed [MV_W-1:0]     mvp_y_i,
  input  logic                       cand_ready_i,
  output logic                       cand_valid_o,
  output logic signed [MV_W-1:0]     cand_mvx_o,
  output logic signed [MV_W-1:0]     cand_mvy_o,
  output logic        [MVC_W-1:0]    mv_cost_o,
  input  logic                       cost_v_i,
  input  logic        [COST_W-1:0]   cost16x16_i,
  input  logic        [2*COST_W-1:0] cost16x8_i,
  input  logic        [2*COST_W-1:0] cost8x16_i,
  input  logic        [COST_W-1:0]   thresh_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic        [COST_W-1:0]   best16x16_cost_o,
  output logic        [2*MV_W-1:0]   best16x16_mv_o,
  output logic        [2*COST_W-1:0] best16x8_cost_o,
  output logic        [2*COST_W-1:0] best8x16_cost_o,
  output logic        [4*MV_W-1:0]   best16x8_mv_o,
  output logic        [4*MV_W-1:0]   best8x16_mv_o
);

  localparam int SPAN = 2 * SR;
  localparam int N    = SPAN * SPAN;
  localparam int XW   = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam int CW   = $clog2(N + 1);

  state_t                state;
  logic [LAMBDA_W-1:0]   lambda_q;
  logic signed [MV_W-1:0] mvp_x_q, mvp_y_q;
  logic [XW-1:0]         iss_x, iss_y, ret_x, ret_y;
  logic [XW-1:0]         iss_x_nxt, iss_y_nxt, ret_x_nxt, ret_y_nxt;
  logic [CW-1:0]         iss_cnt, ret_cnt;
  logic [COST_W-1:0]     best_cost [NPART];
  logic [2*MV_W-1:0]     best_mv   [NPART];
  logic [COST_W-1:0]     part_cost [NPART];
  logic [2*MV_W-1:0]     ret_mv;

  logic                  accept, last_iss, ret_ok, early_stop;
  logic signed [MV_W-1:0] cm_x, cm_y, cm_px, cm_py;
  logic [LAMBDA_W-1:0]   cm_lambda;
  logic [MVC_W-1:0]      cm_cost;

  function automatic logic signed [MV_W-1:0] to_mv(input logic [XW-1:0] idx);
    return MV_W'(idx) - MV_W'(SR);
  endfunction

  always_comb begin
    iss_x_nxt = (iss_x == XW'(SPAN - 1)) ? '0 : iss_x + XW'(1);
    iss_y_nxt = (iss_x == XW'(SPAN - 1)) ? iss_y + XW'(1) : iss_y;
    ret_x_nxt = (ret_x == XW'(SPAN - 1)) ? '0 : ret_x + XW'(1);
    ret_y_nxt = (ret_x == XW'(SPAN - 1)) ? ret_y + XW'(1) : ret_y;
    part_cost[P16X16]  = cost16x16_i;
    part_cost[P16X8_T] = cost16x8_i[COST_W-1:0];
    part_cost[P16X8_B] = cost16x8_i[2*COST_W-1:COST_W];
    part_cost[P8X16_L] = cost8x16_i[COST_W-1:0];
    part_cost[P8X16_R] = cost8x16_i[2*COST_W-1:COST_W];
  end

  assign accept   = cand_valid_o & cand_ready_i;
  assign last_iss = (iss_cnt == CW'(N - 1));
  assign ret_ok   = cost_v_i && (state == S_ISSUE || state == S_DRAIN) && (ret_cnt != iss_cnt);
  assign ret_mv   = {to_mv(ret_y), to_mv(ret_x)};

`ifdef IME_EARLY_TERM_EN
  assign early_stop = ret_ok && (cost16x16_i < thresh_i);
`else
  logic unused_thresh;
  assign early_stop    = 1'b0;
  assign unused_thresh = ^thresh_i;
`endif

  // In IDLE the cost unit sees the first candidate with the live start-time inputs,
  // so candidate 0 and its cost are registered together on the start edge.
  assign cm_x      = (state == S_IDLE) ? to_mv('0) : to_mv(iss_x_nxt);
  assign cm_y      = (state == S_IDLE) ? to_mv('0) : to_mv(iss_y_nxt);
  assign cm_px     = (state == S_IDLE) ? mvp_x_i  : mvp_x_q;
  assign cm_py     = (state == S_IDLE) ? mvp_y_i  : mvp_y_q;
  assign cm_lambda = (state == S_IDLE) ? lambda_i : lambda_q;

  ime_mvd_cost #(
    .MV_W     (MV_W),
    .LAMBDA_W (LAMBDA_W),
    .MVC_W    (MVC_W)
  ) u_mvd_cost (
    .mvx    (cm_x),
    .mvy    (cm_y),
    .mvp_x  (cm_px),
    .mvp_y  (cm_py),
    .lambda (cm_lambda),
    .cost   (cm_cost)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      lambda_q     <= '0;
      mvp_x_q      <= '0;
      mvp_y_q      <= '0;
      iss_x        <= '0;
      iss_y        <= '0;
      ret_x        <= '0;
      ret_y        <= '0;
      iss_cnt      <= '0;
      ret_cnt      <= '0;
      cand_valid_o <= 1'b0;
      cand_mvx_o   <= '0;
      cand_mvy_o   <= '0;
      mv_cost_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      // NOTE: the best arrays are five flop entries, not a RAM, so resetting them is cheap and keeps outputs defined.
      for (int p = 0; p < NPART; p++) begin
        best_cost[p] <= '1;
        best_mv[p]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (ret_ok) begin
        for (int p = 0; p < NPART; p++) begin
          if (part_cost[p] < best_cost[p]) begin
            best_cost[p] <= part_cost[p];
            best_mv[p]   <= ret_mv;
          end
        end
        ret_x   <= ret_x_nxt;
        ret_y   <= ret_y_nxt;
        ret_cnt <= ret_cnt + CW'(1);
      end

      case (state)
        S_IDLE: begin
          if (start_i) begin
            lambda_q     <= lambda_i;
            mvp_x_q      <= mvp_x_i;
            mvp_y_q      <= mvp_y_i;
            iss_x        <= '0;
            iss_y        <= '0;
            ret_x        <= '0;
            ret_y        <= '0;
            iss_cnt      <= '0;
            ret_cnt      <= '0;
            cand_valid_o <= 1'b1;
            cand_mvx_o   <= to_mv('0);
            cand_mvy_o   <= to_mv('0);
            mv_cost_o    <= cm_cost;
            busy_o       <= 1'b1;
            for (int p = 0; p < NPART; p++) best_cost[p] <= '1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            iss_x      <= iss_x_nxt;
            iss_y      <= iss_y_nxt;
            iss_cnt    <= iss_cnt + CW'(1);
            cand_mvx_o <= cm_x;
            cand_mvy_o <= cm_y;
            mv_cost_o  <= cm_cost;
          end
          if ((accept && last_iss) || early_stop) begin
            cand_valid_o <= 1'b0;
            state        <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ret_cnt == iss_cnt) begin
            done_o <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign best16x16_cost_o = best_cost[P16X16];
  assign best16x16_mv_o   = best_mv[P16X16];
  assign best16x8_cost_o  = {best_cost[P16X8_B], best_cost[P16X8_T]};
  assign best16x8_mv_o    = {best_mv[P16X8_B], best_mv[P16X8_T]};
  assign best8x16_cost_o  = {best_cost[P8X16_R], best_cost[P8X16_L]};
  assign best8x16_mv_o    = {best_mv[P8X16_R], best_mv[P8X16_L]};

endmodule

// File: tb/tb_ime_search_ctrl.sv
// Scoreboard bench for ime_search_ctrl (SR=2): expected candidates and results are queued
// at issue; negedge monitors pop and compare when the DUT transfers or signals done.
module tb_ime_search_ctrl;

  localparam int SR = 2, MV_W = 10, LAMBDA_W = 7, COST_W = 16, MVC_W = 12;
  localparam int N  = 4 * SR * SR;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start_i = 1'b0;
  logic [LAMBDA_W-1:0] lambda_i = '0;
  logic signed [MV_W-1:0] mvp_x_i = '0, mvp_y_i = '0;
  logic cand_ready_i = 1'b0;
  logic cand_valid_o;
  logic signed [MV_W-1:0] cand_mvx_o, cand_mvy_o;
  logic [MVC_W-1:0] mv_cost_o;
  logic cost_v_i = 1'b0;
  logic [COST_W-1:0] cost16x16_i = '0;
  logic [2*COST_W-1:0] cost16x8_i = '0, cost8x16_i = '0;
  logic [COST_W-1:0] thresh_i = '0;
  logic busy_o, done_o;
  logic [COST_W-1:0] best16x16_cost_o;
  logic [2*MV_W-1:0] best16x16_mv_o;
  logic [2*COST_W-1:0] best16x8_cost_o, best8x16_cost_o;
  logic [4*MV_W-1:0] best16x8_mv_o, best8x16_mv_o;

  always #5 clk = ~clk;

  ime_search_ctrl #(.SR(SR), .MV_W(MV_W), .LAMBDA_W(LAMBDA_W), .COST_W(COST_W), .MVC_W(MVC_W)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .lambda_i(lambda_i),
    .mvp_x_i(mvp_x_i), .mvp_y_i(mvp_y_i), .cand_ready_i(cand_ready_i),
    .cand_valid_o(cand_valid_o), .cand_mvx_o(cand_mvx_o), .cand_mvy_o(cand_mvy_o),
    .mv_cost_o(mv_cost_o), .cost_v_i(cost_v_i), .cost16x16_i(cost16x16_i),
    .cost16x8_i(cost16x8_i), .cost8x16_i(cost8x16_i), .thresh_i(thresh_i),
    .busy_o(busy_o), .done_o(done_o), .best16x16_cost_o(best16x16_cost_o),
    .best16x16_mv_o(best16x16_mv_o), .best16x8_cost_o(best16x8_cost_o),
    .best8x16_cost_o(best8x16_cost_o), .best16x8_mv_o(best16x8_mv_o),
    .best8x16_mv_o(best8x16_mv_o)
  );

  typedef struct { int mvx; int mvy; int cost; } cand_t;
  typedef struct { int cost[5]; int mvx[5]; int mvy[5]; } res_t;
  typedef struct { int due; int mvx; int mvy; } pend_t;

  cand_t exp_cand[$];
  res_t  exp_res[$];
  pend_t pend[$];
  res_t  er;

  int errors = 0, checks = 0, cyc = 0;
  int n_issued = 0, n_ret = 0, done_cnt = 0;
  int cur_mode = 0, cur_lat = 1, cur_lambda = 0;
  bit cur_rnd = 1'b0, cur_full = 1'b1;
  bit stall_prev = 1'b0;
  int held_x, held_y, held_c;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int elen(input int d);
    int v, n;
    v = 2 * iabs(d) + 1;
    n = 0;
    while (v > 1) begin
      v = v >> 1;
      n++;
    end
    return 2 * n + 1;
  endfunction

  function automatic int mvc_model(input int lam, input int px, input int py, input int x, input int y);
    int c;
    c = lam * (elen(x - px) + elen(y - py));
    return (c > 4095) ? 4095 : c;
  endfunction

  // Cost stage stand-in: mode 0 flat, mode 1 per-partition bowls, mode 2 one low 16x16 hit.
  function automatic int cost_of(input int mode, input int p, input int x, input int y);
    if (mode == 1) begin
      if (p == 0) return 50 + 10 * (iabs(x) + iabs(y - 1));
      if (p == 1) return 50 + 10 * (iabs(x + 1) + iabs(y + 1));
      if (p == 3) return 50 + 10 * (iabs(x - 1) + iabs(y + 2));
      return 100;
    end
    if (mode == 2 && p == 0) return (x == 1 && y == -2) ? 40 : 100;
    return 100;
  endfunction

  function automatic int dut_cost(input int p);
    case (p)
      0: return int'(best16x16_cost_o);
      1: return int'(best16x8_cost_o[15:0]);
      2: return int'(best16x8_cost_o[31:16]);
      3: return int'(best8x16_cost_o[15:0]);
      default: return int'(best8x16_cost_o[31:16]);
    endcase
  endfunction

  function automatic int dut_mvx(input int p);
    case (p)
      0: return int'($signed(best16x16_mv_o[9:0]));
      1: return int'($signed(best16x8_mv_o[9:0]));
      2: return int'($signed(best16x8_mv_o[29:20]));
      3: return int'($signed(best8x16_mv_o[9:0]));
      default: return int'($signed(best8x16_mv_o[29:20]));
    endcase
  endfunction

  function automatic int dut_mvy(input int p);
    case (p)
      0: return int'($signed(best16x16_mv_o[19:10]));
      1: return int'($signed(best16x8_mv_o[19:10]));
      2: return int'($signed(best16x8_mv_o[39:30]));
      3: return int'($signed(best8x16_mv_o[19:10]));
      default: return int'($signed(best8x16_mv_o[39:30]));
    endcase
  endfunction

  // Responder: records accepted candidates and returns their costs after cur_lat cycles.
  always @(posedge clk) begin
    pend_t p;
    cyc++;
    if (rstn && cand_valid_o && cand_ready_i) begin
      pend.push_back('{due: cyc + cur_lat, mvx: int'(cand_mvx_o), mvy: int'(cand_mvy_o)});
      n_issued++;
    end
    #1;
    cost_v_i = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      cost_v_i    = 1'b1;
      cost16x16_i = 16'(cost_of(cur_mode, 0, p.mvx, p.mvy));
      cost16x8_i  = {16'(cost_of(cur_mode, 2, p.mvx, p.mvy)), 16'(cost_of(cur_mode, 1, p.mvx, p.mvy))};
      cost8x16_i  = {16'(cost_of(cur_mode, 4, p.mvx, p.mvy)), 16'(cost_of(cur_mode, 3, p.mvx, p.mvy))};
      n_ret++;
    end
  end

  always @(posedge clk) begin
    #1;
    cand_ready_i = cur_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: candidate transfers, stall stability and done results.
  always @(negedge clk) begin
    cand_t c;
    res_t r;
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && cand_valid_o) begin
        check("stall_mvx", cand_mvx_o, held_x);
        check("stall_mvy", cand_mvy_o, held_y);
        check("stall_cost", mv_cost_o, held_c);
      end
      stall_prev = cand_valid_o && !cand_ready_i;
      held_x = int'(cand_mvx_o);
      held_y = int'(cand_mvy_o);
      held_c = int'(mv_cost_o);
      if (cand_valid_o && cand_ready_i) begin
        check("cand_expected", longint'(exp_cand.size() > 0), 1);
        if (exp_cand.size() > 0) begin
          c = exp_cand.pop_front();
          check("cand_mvx", cand_mvx_o, c.mvx);
          check("cand_mvy", cand_mvy_o, c.mvy);
          check("mv_cost", mv_cost_o, c.cost);
          if (cur_lambda == 4 && c.mvx == -2 && c.mvy == 1) check("mv_cost_hand", mv_cost_o, 32);
        end
      end
      if (done_o) begin
        done_cnt++;
        check("done_after_all_results", n_ret, n_issued);
        if (cur_full) check("done_result_count", n_ret, N);
        check("res_expected", longint'(exp_res.size() > 0), 1);
        if (exp_res.size() > 0) begin
          r = exp_res.pop_front();
          for (int p = 0; p < 5; p++) begin
            check($sformatf("best_cost[%0d]", p), dut_cost(p), r.cost[p]);
            check($sformatf("best_mvx[%0d]", p), dut_mvx(p), r.mvx[p]);
            check($sformatf("best_mvy[%0d]", p), dut_mvy(p), r.mvy[p]);
          end
        end
      end
    end
  end

  task automatic set_uniform(input int c);
    for (int p = 0; p < 5; p++) begin
      er.cost[p] = c;
      er.mvx[p]  = -2;
      er.mvy[p]  = -2;
    end
  endtask

  task automatic set_shaped();
    set_uniform(100);
    er.cost[0] = 50; er.mvx[0] = 0;  er.mvy[0] = 1;
    er.cost[1] = 50; er.mvx[1] = -1; er.mvy[1] = -1;
    er.cost[3] = 50; er.mvx[3] = 1;  er.mvy[3] = -2;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, cand_valid_o, 0);
    check({tag, "_mvx"}, cand_mvx_o, 0);
    check({tag, "_mvy"}, cand_mvy_o, 0);
    check({tag, "_mv_cost"}, mv_cost_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_c16x16"}, best16x16_cost_o, 64'hffff);
    check({tag, "_c16x8"}, best16x8_cost_o, 64'hffff_ffff);
    check({tag, "_c8x16"}, best8x16_cost_o, 64'hffff_ffff);
    check({tag, "_mv16x16"}, best16x16_mv_o, 0);
    check({tag, "_mv16x8"}, best16x8_mv_o, 0);
    check({tag, "_mv8x16"}, best8x16_mv_o, 0);
  endtask

  task automatic launch(input int mode, input int lam, input int px, input int py,
                        input bit rnd, input int lat, input bit full);
    cur_mode = mode; cur_lambda = lam; cur_rnd = rnd; cur_lat = lat; cur_full = full;
    n_issued = 0; n_ret = 0; done_cnt = 0;
    exp_cand.delete();
    for (int k = 0; k < N; k++) begin
      int x, y;
      x = (k % (2 * SR)) - SR;
      y = (k / (2 * SR)) - SR;
      exp_cand.push_back('{mvx: x, mvy: y, cost: mvc_model(lam, px, py, x, y)});
    end
    exp_res.push_back(er);
    @(posedge clk); #1;
    lambda_i = LAMBDA_W'(lam); mvp_x_i = MV_W'(px); mvp_y_i = MV_W'(py);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    // Inputs are only sampled at start; scramble them for the rest of the search.
    lambda_i = 7'h7f; mvp_x_i = 10'sd100; mvp_y_i = -10'sd77;
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic run_search(input int mode, input int lam, input int px, input int py,
                            input bit rnd, input int lat, input bit full);
    int n;
    launch(mode, lam, px, py, rnd, lat, full);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      start_i = rnd && (n == 7);
    end
    start_i = 1'b0;
    check("done_seen_within_budget", longint'(done_cnt > 0), 1);
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", busy_o, 0);
    check("done_low_after", done_o, 0);
    if (full) begin
      check("all_cands_issued", exp_cand.size(), 0);
      check("issue_count", n_issued, N);
    end else begin
      exp_cand.delete();
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rstn = 1'b1;

    // Flat costs: tie rule keeps (-2,-2) everywhere.
    set_uniform(100);
    run_search(0, 0, 0, 0, 1'b0, 1, 1'b1);

    // Lambda 4, predictor (1,0): per-candidate MV cost.
    run_search(0, 4, 1, 0, 1'b0, 1, 1'b1);

    // cost_v_i while idle is ignored and results hold after done.
    @(negedge clk);
    cost16x16_i = '0; cost16x8_i = '0; cost8x16_i = '0; cost_v_i = 1'b1;
    @(negedge clk);
    check("idle_cost_ignored", best16x16_cost_o, 100);
    check("idle_c8x16_ignored", best8x16_cost_o[15:0], 100);
    check("idle_mv_hold", best16x16_mv_o, {10'(-2), 10'(-2)});

    // MV cost saturation.
    run_search(0, 127, -500, 500, 1'b0, 1, 1'b1);

    // Independent per-partition minima.
    set_shaped();
    run_search(1, 0, 0, 0, 1'b0, 1, 1'b1);

    // Random back-pressure, 5-cycle result latency, ignored mid-search start.
    run_search(1, 2, -1, 1, 1'b1, 5, 1'b1);

    // Reset in the middle of ISSUE, then a clean search.
    set_uniform(100);
    launch(0, 0, 0, 0, 1'b0, 1, 1'b1);
    n = 0;
    while (n_issued < 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("reset_setup_issued", longint'(n_issued >= 5), 1);
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    check_reset("midreset");
    pend.delete(); exp_cand.delete(); exp_res.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_search(0, 0, 0, 0, 1'b0, 1, 1'b1);

`ifdef IME_EARLY_TERM_EN
    // Early termination on a 16x16 cost of 40 at index 3 with threshold 50.
    thresh_i = 16'd50;
    set_uniform(100);
    er.cost[0] = 40; er.mvx[0] = 1; er.mvy[0] = -2;
    run_search(2, 0, 0, 0, 1'b0, 2, 1'b0);
    check("et_stopped_early", longint'(n_issued < N), 1);
    check("et_issue_bound", longint'(n_issued <= 4 + 2 + 2), 1);
    check("et_returns_match", n_ret, n_issued);
    thresh_i = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ime_search_ctrl.md
Name: ime_search_ctrl

Overview:
- Sequences full-search integer motion estimation for one macroblock.
- Generates candidate MVs in raster order over a square search window and drives them into the SAD array, one candidate per accepted cycle.
- Produces the per-candidate MV cost consumed by the cost adders.
- Collects the returned 16x16/16x8/8x16 costs and keeps the best cost and MV per partition.

Parameters:
- SR, 16: search range; candidates are mvx, mvy in [-SR, SR-1] (integer pel).
- MV_W, 10: signed MV component width.
- LAMBDA_W, 7: unsigned lambda width.
- COST_W, 16: cost width for all partitions; saturating.
- MVC_W, 12: mv_cost width (equals `MV_COST_BITS` in enc_defines).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begin search for the current MB
- lambda_i  in  LAMBDA_W  lambda, sampled at start
- mvp_x_i, mvp_y_i  in  MV_W  signed MV predictor, sampled at start
- cand_ready_i  in  1  SAD array accepts a candidate this cycle
- cand_valid_o  out  1  candidate valid
- cand_mvx_o, cand_mvy_o  out  MV_W  candidate MV
- mv_cost_o  out  MVC_W  cost of the current candidate, aligned with cand_valid_o
- cost_v_i  in  1  result valid from cost stage (in issue order)
- cost16x16_i  in  COST_W  16x16 cost
- cost16x8_i  in  2*COST_W  16x8 costs; [0] top
- cost8x16_i  in  2*COST_W  8x16 costs; [0] left
- thresh_i  in  COST_W  early-termination threshold (see Optional Feature)
- busy_o  out  1  search in progress
- done_o  out  1  one-cycle pulse; results final
- best16x16_cost_o  out  COST_W
- best16x16_mv_o  out  2*MV_W  {mvy, mvx}
- best16x8_cost_o, best8x16_cost_o  out  2*COST_W
- best16x8_mv_o, best8x16_mv_o  out  4*MV_W

Behaviour:
- Reset: FSM is IDLE; every output is 0, except best costs, which reset to all-ones.
- FSM states:
  - IDLE: on start_i, latch lambda and mvp, set issue index to 0 and return index to 0, load best costs with all-ones, go to ISSUE.
  - ISSUE: hold cand_valid_o = 1. A candidate is transferred when valid and ready are both high; the issue index then advances. After index N-1 (N = 4*SR*SR) is accepted, go to DRAIN. While cand_ready_i = 0, hold MV and cost stable.
  - DRAIN: cand_valid_o = 0. Wait until return index = N.
  - DONE: assert done_o for one cycle, then go to IDLE.
- busy_o = 1 in every state except IDLE.
- Candidate MV from issue index k: mvx = (k mod 2SR) - SR, mvy = (k div 2SR) - SR. Implement as x/y counters with wrap, not a divider.
- MV cost:
  - mv_cost_o = lambda * (len(mvx - mvp_x) + len(mvy - mvp_y)).
  - len(d) = 2*floor(log2(2|d|+1)) + 1 (se(v) Exp-Golomb length); len(0) = 1.
  - mv_cost_o is registered with the candidate and saturates at MVC_W.
- Results:
  - cost_v_i may arrive in the same cycle as an issue.
  - The returned MV is regenerated from a separate return x/y counter; there is no FIFO.
  - Update a partition's best cost and MV only when new cost < best cost (strict), so ties keep the earliest raster candidate.
  - Each of the five partitions is compared independently.
- start_i while busy: ignored.
- cost_v_i in IDLE: ignored.
- Reset mid-search: abort immediately to IDLE, with outputs at their reset values.
- Best outputs hold their values after done until the next start.

Optional Feature:
- Macro IME_EARLY_TERM_EN.
- Defined: in ISSUE, when a returned best16x16 < thresh_i, stop issuing and go to DRAIN. The candidate already in flight completes and is still compared. done_o fires after outstanding results return, with the return count equal to the issue count.
- Undefined: thresh_i is unused and the full window is always searched.

Decomposition:
- Shared package/defines (enc_defines): MV_W, COST_W, `MV_COST_BITS`, FSM state encodings, and the packed MV layout {mvy, mvx}.
- One sub-module: ime_mvd_cost.
  - Combinational len() for two components plus the lambda multiply.
  - Instantiated once; its output is registered in the parent.

Test Plan:
- SR=2, lambda=0, mvp=(0,0), constant cost 100 for all partitions, cand_ready_i = 1 → 16 candidates (-2,-2)..(1,1) in raster order; best MVs all (-2,-2) (tie rule); done_o pulses once.
- lambda=4, mvp=(1,0), candidate (-2,1): len(-3)=5, len(1)=3 → mv_cost_o = 32.
- Cost model with 16x16 minimum at (0,1), top 16x8 at (-1,-1), left 8x16 at (1,-2) → each best MV is reported independently.
- Random cand_ready_i (50%) with a 5-cycle result latency → no candidate skipped or duplicated, MV stable during stall, done_o only after the 16th result.
- Assert rstn low mid-ISSUE, then restart → outputs return to reset values; the second search completes correctly.
- IME_EARLY_TERM_EN, thresh=50, cost 40 at index 3 → issue stops within latency; done_o after outstanding results; best16x16 mv = index 3.
